// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//   Controller for one fully-connected layer of neuron instances. It buffers a
//   complete input vector, broadcasts it as one contiguous burst to every
//   neuron, collects one result per neuron and serializes the results onto a
//   ready/valid stream for the next layer.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            asynchronous active-high reset
//   s_data/s_valid/s_ready       input vector stream from the previous layer
//   n_input/n_input_valid        registered broadcast to all neurons
//   n_out/n_out_valid            neuron results (neuron k at k*dataWidth) and strobes
//   m_data/m_valid/m_ready/m_last  serialized result stream, m_last on the final neuron
//   busy           high whenever the sequencer is not filling
//   err            sticky protocol error (duplicate or out-of-phase result strobe)
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int dataWidth = 32,
  parameter int numInput  = 784,
  parameter int numNeuron = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [dataWidth-1:0]           s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [dataWidth-1:0]           n_input,
  output logic                           n_input_valid,
  input  logic [numNeuron*dataWidth-1:0] n_out,
  input  logic [numNeuron-1:0]           n_out_valid,
  output logic [dataWidth-1:0]           m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           busy,
  output logic                           err
);

  localparam int CntW  = (numInput  > 1) ? $clog2(numInput)  : 1;
  localparam int NidxW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [CntW-1:0]  LastIn = CntW'(numInput - 1);
  localparam logic [NidxW-1:0] LastN  = NidxW'(numNeuron - 1);

  typedef enum logic [1:0] {FILL, BCAST, WAIT, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [NidxW-1:0]       nidx_q, nidx_d;
  logic [numNeuron-1:0]   done_q, done_d;
  logic [numNeuron-1:0]   capture;
  logic                   err_q, err_d;
  logic [dataWidth-1:0]   n_input_q, n_input_d;
  logic                   n_input_valid_q, n_input_valid_d;
  logic [dataWidth-1:0]   in_buf_q [numInput];
  logic [dataWidth-1:0]   res_q    [numNeuron];
  logic                   s_hs, m_hs;

  assign s_ready       = (state_q == FILL);
  assign busy          = (state_q != FILL);
  assign m_valid       = (state_q == DRAIN);
  // Gated so m_data reads 0 outside DRAIN even though res_q is never reset.
  assign m_data        = m_valid ? res_q[nidx_q] : '0;
  assign m_last        = m_valid && (nidx_q == LastN);
  assign n_input       = n_input_q;
  assign n_input_valid = n_input_valid_q;
  assign err           = err_q;
  assign s_hs          = s_valid & s_ready;
  assign m_hs          = m_valid & m_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    nidx_d          = nidx_q;
    done_d          = done_q;
    capture         = '0;
    err_d           = err_q;
    n_input_d       = '0;
    n_input_valid_d = 1'b0;

    case (state_q)
      FILL: begin
        if (s_hs) begin
          if (wr_cnt_q == LastIn) begin
            wr_cnt_d = '0;
            state_d  = BCAST;
          end else begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
          end
        end
      end

      BCAST: begin
        // One buffer read per cycle; the registered output lags by one cycle.
        n_input_d       = in_buf_q[rd_cnt_q];
        n_input_valid_d = 1'b1;
        if (rd_cnt_q == LastIn) begin
          rd_cnt_d = '0;
          state_d  = WAIT;
        end else begin
          rd_cnt_d = rd_cnt_q + CntW'(1);
        end
      end

      WAIT: begin
        // First strobe per neuron wins; repeats are flagged and dropped.
        capture = n_out_valid & ~done_q;
        if (|(n_out_valid & done_q)) err_d = 1'b1;
        if (&(done_q | n_out_valid)) begin
          done_d  = '0;
          state_d = DRAIN;
        end else begin
          done_d = done_q | n_out_valid;
        end
      end

      DRAIN: begin
        if (m_hs) begin
          if (nidx_q == LastN) begin
            nidx_d  = '0;
            state_d = FILL;
          end else begin
            nidx_d = nidx_q + NidxW'(1);
          end
        end
      end

      default: state_d = FILL;
    endcase

    // Result strobes are only legal while waiting for results.
    if ((state_q != WAIT) && (|n_out_valid)) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= FILL;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      nidx_q          <= '0;
      done_q          <= '0;
      err_q           <= 1'b0;
      n_input_q       <= '0;
      n_input_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      nidx_q          <= nidx_d;
      done_q          <= done_d;
      err_q           <= err_d;
      n_input_q       <= n_input_d;
      n_input_valid_q <= n_input_valid_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; they are always written
  // before being read, and leaving them reset-free lets them map to RAM.
  always_ff @(posedge clk) begin
    if (s_hs) in_buf_q[wr_cnt_q] <= s_data;
    for (int k = 0; k < numNeuron; k++) begin
      if (capture[k]) res_q[k] <= n_out[k*dataWidth +: dataWidth];
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//   Self-checking bench for layer_sequencer. A small instance (4 inputs,
//   3 neurons) takes directed and randomized traffic checked against a
//   behavioural model (queues of words, first-strobe-wins result table, sticky
//   error flag). A default-size instance (784 inputs, 30 neurons) runs one
//   full vector.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NN = 3;
  localparam int BNI = 784;
  localparam int BNN = 30;

  logic clk;
  logic rst;

  // Small instance
  logic [DW-1:0]    s_data;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    n_input;
  logic             n_input_valid;
  logic [NN*DW-1:0] n_out;
  logic [NN-1:0]    n_out_valid;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             busy;
  logic             err;

  // Default-size instance
  logic [DW-1:0]     b_s_data;
  logic              b_s_valid;
  logic              b_s_ready;
  logic [DW-1:0]     b_n_input;
  logic              b_n_input_valid;
  logic [BNN*DW-1:0] b_n_out;
  logic [BNN-1:0]    b_n_out_valid;
  logic [DW-1:0]     b_m_data;
  logic              b_m_valid;
  logic              b_m_ready;
  logic              b_m_last;
  logic              b_busy;
  logic              b_err;

  layer_sequencer #(.dataWidth(DW), .numInput(NI), .numNeuron(NN)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .n_input(n_input), .n_input_valid(n_input_valid),
    .n_out(n_out), .n_out_valid(n_out_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .err(err)
  );

  layer_sequencer dut_big (
    .clk(clk), .rst(rst),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .n_input(b_n_input), .n_input_valid(b_n_input_valid),
    .n_out(b_n_out), .n_out_valid(b_n_out_valid),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] vec [$];
  logic [DW-1:0] res_exp [NN];
  logic [NN-1:0] done_m;
  logic [DW-1:0] stb_val [NN];
  bit            exp_err;
  bit            rdy_q [$];
  bit            rand_rdy;
  int            hs_cyc;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_n_input_valid"}, n_input_valid, 0);
    check({tag, "_m_valid"}, m_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    exp_err = 1'b0;
    done_m  = '0;
  endtask

  // Send vec word by word with a random number of idle cycles before each.
  task automatic send_vec(input int gap_min, input int gap_max);
    for (int i = 0; i < vec.size(); i++) begin
      repeat ($urandom_range(gap_min, gap_max)) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        step();
      end
      s_valid = 1'b1;
      s_data  = vec[i];
      check("fill_s_ready", s_ready, 1);
      hs_cyc = cyc;
      step();
    end
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  // Observe the broadcast that follows the final fill handshake. Optionally
  // strobe neuron 0 during the second beat, which must be flagged and ignored.
  task automatic check_bcast(input bit strobe_mid);
    int beats = 0;
    int first = -1;
    int last  = -1;
    check("bcast_s_ready_drop", s_ready, 0);
    check("bcast_busy", busy, 1);
    for (int t = 0; t < NI + 3; t++) begin
      step();
      n_out_valid = '0;
      if (n_input_valid) begin
        if (beats == 0) first = cyc;
        last = cyc;
        if (beats < NI) check("bcast_data", n_input, vec[beats]);
        if (beats == 1 && strobe_mid) begin
          n_out_valid = 3'b001;
          n_out[0 +: DW] = 32'h77;
          exp_err = 1'b1;
        end
        beats++;
      end
    end
    check("bcast_count", beats, NI);
    check("bcast_latency", first, hs_cyc + 2);
    check("bcast_contig", last - first, NI - 1);
    check("bcast_err", err, exp_err);
  endtask

  task automatic do_strobe(input logic [NN-1:0] mask);
    n_out_valid = mask;
    for (int k = 0; k < NN; k++) begin
      n_out[k*DW +: DW] = stb_val[k];
      if (mask[k]) begin
        if (done_m[k]) exp_err = 1'b1;
        else begin
          res_exp[k] = stb_val[k];
          done_m[k]  = 1'b1;
        end
      end
    end
    step();
    n_out_valid = '0;
    for (int k = 0; k < NN; k++) n_out[k*DW +: DW] = $urandom;
    check("strobe_err", err, exp_err);
  endtask

  task automatic drain();
    int idx = 0;
    bit v;
    for (int t = 0; t < 100 && idx < NN; t++) begin
      check("drain_m_valid", m_valid, 1);
      check("drain_m_data", m_data, res_exp[idx]);
      check("drain_m_last", m_last, (idx == NN - 1) ? 1 : 0);
      v = m_valid;
      if (rdy_q.size() > 0) m_ready = rdy_q.pop_front();
      else m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (v && m_ready) idx++;
    end
    m_ready = 1'b0;
    check("drain_count", idx, NN);
    check("drain_end_m_valid", m_valid, 0);
    check("drain_end_s_ready", s_ready, 1);
    check("drain_end_busy", busy, 0);
    check("drain_end_err", err, exp_err);
    done_m = '0;
  endtask

  initial begin
    logic [NN-1:0] mask;
    int beats;
    int first;
    int last;
    int idx;

    rst = 1'b1;
    s_data = '0; s_valid = 1'b0; n_out = '0; n_out_valid = '0; m_ready = 1'b0;
    b_s_data = '0; b_s_valid = 1'b0; b_n_out = '0; b_n_out_valid = '0; b_m_ready = 1'b0;
    rand_rdy = 1'b0;

    // Reset values
    do_reset();
    check_idle("reset");
    check("reset_err", err, 0);
    check("reset_m_last", m_last, 0);
    check("reset_n_input", n_input, 0);
    check("reset_m_data", m_data, 0);
    check("reset_big_s_ready", b_s_ready, 1);
    check("reset_big_busy", b_busy, 0);

    // Fill with gaps, out-of-order results, backpressured drain
    vec = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_vec(1, 1);
    check_bcast(1'b0);
    stb_val = '{32'h11, 32'h22, 32'h33};
    do_strobe(3'b010);
    check("wait_no_m_valid", m_valid, 0);
    do_strobe(3'b101);
    rdy_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    drain();

    // Second vector back to back; duplicate strobe keeps the first value
    vec = '{32'd5, 32'd6, 32'd7, 32'd8};
    send_vec(0, 0);
    check_bcast(1'b0);
    stb_val = '{32'h11, 32'h0, 32'h0};
    do_strobe(3'b001);
    stb_val = '{32'h99, 32'h22, 32'h33};
    do_strobe(3'b001);
    check("dup_err", err, 1);
    do_strobe(3'b110);
    drain();

    // Clear err, then a strobe during broadcast
    do_reset();
    check("reset2_err", err, 0);
    vec = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send_vec(0, 2);
    check_bcast(1'b1);
    check("bcast_strobe_err", err, 1);
    stb_val = '{32'h44, 32'h55, 32'h66};
    do_strobe(3'b111);
    drain();

    // Reset in the middle of a broadcast
    vec = '{32'd20, 32'd21, 32'd22, 32'd23};
    send_vec(0, 0);
    beats = 0;
    for (int t = 0; t < 10 && beats < 2; t++) begin
      step();
      if (n_input_valid) beats++;
    end
    check("midrst_reached", beats, 2);
    rst = 1'b1;
    #1;
    check("midrst_n_input_valid", n_input_valid, 0);
    check("midrst_busy", busy, 0);
    repeat (2) step();
    rst = 1'b0;
    exp_err = 1'b0;
    done_m  = '0;
    check_idle("midrst_release");
    check("midrst_err", err, 0);
    vec = '{32'd10, 32'd11, 32'd12, 32'd13};
    send_vec(0, 2);
    check_bcast(1'b0);
    stb_val = '{32'h1, 32'h2, 32'h3};
    do_strobe(3'b100);
    do_strobe(3'b011);
    drain();

    // Randomized vectors, strobe patterns and backpressure
    rand_rdy = 1'b1;
    for (int it = 0; it < 8; it++) begin
      vec = {};
      for (int i = 0; i < NI; i++) vec.push_back($urandom);
      send_vec(0, 3);
      check_bcast(1'b0);
      for (int g = 0; g < 20 && done_m != '1; g++) begin
        repeat ($urandom_range(0, 2)) step();
        mask = NN'($urandom_range(0, 7));
        if ((mask & ~done_m) == '0) begin
          for (int k = 0; k < NN; k++) begin
            if (!done_m[k]) begin
              mask[k] = 1'b1;
              break;
            end
          end
        end
        for (int k = 0; k < NN; k++) stb_val[k] = $urandom;
        do_strobe(mask);
      end
      drain();
    end

    // Default-size instance: one full vector
    for (int i = 0; i < BNI; i++) begin
      b_s_valid = 1'b1;
      b_s_data  = i;
      if (i == 0 || i == BNI - 1) check("big_fill_s_ready", b_s_ready, 1);
      hs_cyc = cyc;
      step();
    end
    b_s_valid = 1'b0;
    check("big_s_ready_drop", b_s_ready, 0);
    beats = 0; first = -1; last = -1;
    for (int t = 0; t < BNI + 4; t++) begin
      step();
      if (b_n_input_valid) begin
        if (beats == 0) first = cyc;
        last = cyc;
        if (beats < BNI && b_n_input !== DW'(beats)) check("big_bcast_data", b_n_input, beats);
        beats++;
      end
    end
    check("big_bcast_count", beats, BNI);
    check("big_bcast_latency", first, hs_cyc + 2);
    check("big_bcast_contig", last - first, BNI - 1);
    b_n_out_valid = '1;
    for (int k = 0; k < BNN; k++) b_n_out[k*DW +: DW] = k * 3 + 7;
    step();
    b_n_out_valid = '0;
    b_m_ready = 1'b1;
    idx = 0;
    for (int t = 0; t < BNN + 5 && idx < BNN; t++) begin
      check("big_drain_m_valid", b_m_valid, 1);
      check("big_drain_m_data", b_m_data, idx * 3 + 7);
      check("big_drain_m_last", b_m_last, (idx == BNN - 1) ? 1 : 0);
      step();
      idx++;
    end
    b_m_ready = 1'b0;
    check("big_drain_count", idx, BNN);
    check("big_end_m_valid", b_m_valid, 0);
    check("big_end_s_ready", b_s_ready, 1);
    check("big_err", b_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
